// File: rtl/lcd_ctrl_pkg.sv
// Shared definitions for the LCD sequencing controller: state encodings,
// command/digit counts and timer sizing helpers.
package lcd_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_PWRUP = 3'd0,
        ST_INIT  = 3'd1,
        ST_IDLE  = 3'd2,
        ST_ADDR  = 3'd3,
        ST_DIGIT = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        STB_IDLE = 2'd0,
        STB_HIGH = 2'd1,
        STB_LOW  = 2'd2
    } stb_state_e;

    localparam int INIT_CMD_CNT = 4;
    localparam int DIGIT_CNT    = 4;

    // A zero-length interval still needs one cycle.
    function automatic int sat1(input int v);
        return (v < 1) ? 1 : v;
    endfunction

    function automatic int timer_width(input int a, input int b, input int c, input int d);
        int m;
        int w;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/lcd_ctrl_strobe.sv
// Enable-strobe timing for one LCD command: after a start request, E is high
// for E_PULSE_CYC cycles, then low for (wait_m1_i + 1) cycles before cmd_done_o.
import lcd_ctrl_pkg::*;

module lcd_ctrl_strobe #(
    parameter int E_PULSE_CYC = 12,
    parameter int TW          = 8
) (
    input  logic          clk,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic [TW-1:0] wait_m1_i,
    output logic          lcd_e_o,
    output logic          cmd_done_o
);

    localparam logic [TW-1:0] E_LOAD = TW'(E_PULSE_CYC - 1);

    stb_state_e    state_q;
    logic [TW-1:0] timer_q;
    logic          lcd_e_q;

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q <= STB_IDLE;
            timer_q <= '0;
            lcd_e_q <= 1'b0;
        end else begin
            case (state_q)
                STB_IDLE: begin
                    if (start_i) begin
                        state_q <= STB_HIGH;
                        timer_q <= E_LOAD;
                        lcd_e_q <= 1'b1;
                    end
                end
                STB_HIGH: begin
                    if (timer_q == '0) begin
                        state_q <= STB_LOW;
                        timer_q <= wait_m1_i;
                        lcd_e_q <= 1'b0;
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                STB_LOW: begin
                    if (timer_q == '0) begin
                        state_q <= STB_IDLE;
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                default: state_q <= STB_IDLE;
            endcase
        end
    end

    // High during the final E-low cycle so the next command's setup follows directly.
    assign cmd_done_o = (state_q == STB_LOW) && (timer_q == '0);
    assign lcd_e_o    = lcd_e_q;

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 power-up init and 4-digit DDRAM writer driving the LCD datapath selects.
// Optional LCD_AUTO_REFRESH_EN adds a periodic internal refresh request.
import lcd_ctrl_pkg::*;

module lcd_ctrl #(
    parameter int PWRUP_CYC    = 750000,
    parameter int E_PULSE_CYC  = 12,
    parameter int CMD_WAIT_CYC = 2000,
    parameter int CLR_WAIT_CYC = 82000,
    parameter int REFRESH_CYC  = 2500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       refresh,
    output logic [1:0] init_sel,
    output logic [1:0] mux_sel,
    output logic       data_sel,
    output logic       DB_sel,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       busy,
    output logic       done
);

    localparam int PWR = sat1(PWRUP_CYC);
    localparam int EPC = sat1(E_PULSE_CYC);
    localparam int CMW = sat1(CMD_WAIT_CYC);
    localparam int CLW = sat1(CLR_WAIT_CYC);
    localparam int TW  = timer_width(PWR, EPC, CMW, CLW);

    localparam logic [TW-1:0] PWR_LAST = TW'(PWR - 1);
    localparam logic [TW-1:0] CMD_M1   = TW'(CMW - 1);
    localparam logic [TW-1:0] CLR_M1   = TW'(CLW - 1);

    state_e        state_q;
    logic [TW-1:0] pwr_cnt_q;
    logic [TW-1:0] wait_m1_q;
    logic          start_q;
    logic          pending_q;
    logic [1:0]    init_sel_q;
    logic [1:0]    mux_sel_q;
    logic          data_sel_q;
    logic          db_sel_q;
    logic          rs_q;
    logic          busy_q;
    logic          done_q;
    logic          cmd_done;
    logic          lcd_e;
    logic          refresh_req;

`ifdef LCD_AUTO_REFRESH_EN
    localparam int REF  = sat1(REFRESH_CYC);
    localparam int RFW  = ($clog2(REF) < 1) ? 1 : $clog2(REF);

    logic [RFW-1:0] ref_cnt_q;
    logic           auto_refresh;

    assign auto_refresh = (ref_cnt_q == RFW'(REF - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            ref_cnt_q <= '0;
        end else if (auto_refresh) begin
            ref_cnt_q <= '0;
        end else begin
            ref_cnt_q <= ref_cnt_q + RFW'(1);
        end
    end

    assign refresh_req = refresh | auto_refresh;
`else
    logic unused_refresh_cfg;
    assign unused_refresh_cfg = (REFRESH_CYC != 0);
    assign refresh_req        = refresh;
`endif

    lcd_ctrl_strobe #(
        .E_PULSE_CYC(EPC),
        .TW         (TW)
    ) u_strobe (
        .clk       (clk),
        .rst_i     (rst),
        .start_i   (start_q),
        .wait_m1_i (wait_m1_q),
        .lcd_e_o   (lcd_e),
        .cmd_done_o(cmd_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_PWRUP;
            pwr_cnt_q  <= '0;
            wait_m1_q  <= '0;
            start_q    <= 1'b0;
            pending_q  <= 1'b0;
            init_sel_q <= 2'd0;
            mux_sel_q  <= 2'd0;
            data_sel_q <= 1'b0;
            db_sel_q   <= 1'b1;
            rs_q       <= 1'b0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            start_q <= 1'b0;
            done_q  <= 1'b0;
            // Requests arriving while busy coalesce into one extra frame.
            if (refresh_req && (state_q != ST_IDLE)) pending_q <= 1'b1;
            case (state_q)
                ST_PWRUP: begin
                    if (pwr_cnt_q == PWR_LAST) begin
                        state_q   <= ST_INIT;
                        wait_m1_q <= CMD_M1;
                        start_q   <= 1'b1;
                    end else begin
                        pwr_cnt_q <= pwr_cnt_q + TW'(1);
                    end
                end
                ST_INIT: begin
                    if (cmd_done) begin
                        start_q <= 1'b1;
                        if (init_sel_q == 2'(INIT_CMD_CNT - 1)) begin
                            state_q   <= ST_ADDR;
                            db_sel_q  <= 1'b0;
                            wait_m1_q <= CMD_M1;
                        end else begin
                            init_sel_q <= init_sel_q + 2'd1;
                            wait_m1_q  <= (init_sel_q == 2'(INIT_CMD_CNT - 2)) ? CLR_M1 : CMD_M1;
                        end
                    end
                end
                ST_IDLE: begin
                    if (refresh_req || pending_q) begin
                        state_q    <= ST_ADDR;
                        pending_q  <= 1'b0;
                        busy_q     <= 1'b1;
                        db_sel_q   <= 1'b0;
                        data_sel_q <= 1'b0;
                        rs_q       <= 1'b0;
                        wait_m1_q  <= CMD_M1;
                        start_q    <= 1'b1;
                    end
                end
                ST_ADDR: begin
                    if (cmd_done) begin
                        state_q    <= ST_DIGIT;
                        db_sel_q   <= 1'b1;
                        data_sel_q <= 1'b1;
                        rs_q       <= 1'b1;
                        mux_sel_q  <= 2'(DIGIT_CNT - 1);
                        start_q    <= 1'b1;
                    end
                end
                ST_DIGIT: begin
                    if (cmd_done) begin
                        if (mux_sel_q == 2'd0) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            mux_sel_q <= mux_sel_q - 2'd1;
                            start_q   <= 1'b1;
                        end
                    end
                end
                default: state_q <= ST_PWRUP;
            endcase
        end
    end

    assign init_sel = init_sel_q;
    assign mux_sel  = mux_sel_q;
    assign data_sel = data_sel_q;
    assign DB_sel   = db_sel_q;
    assign LCD_E    = lcd_e;
    assign LCD_RS   = rs_q;
    assign LCD_RW   = 1'b0;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Bench for lcd_ctrl: a segment/age timeline model checked every cycle, plus
// literal timing and byte expectations for init, frames, refresh and reset abort.
module tb_lcd_ctrl;

    localparam int P   = 10;
    localparam int EP  = 2;
    localparam int CW  = 5;
    localparam int CLR = 20;
    localparam int REF = 200;

    logic       clk = 1'b0;
    logic       rst;
    logic       refresh;
    logic [1:0] init_sel;
    logic [1:0] mux_sel;
    logic       data_sel;
    logic       DB_sel;
    logic       LCD_E;
    logic       LCD_RS;
    logic       LCD_RW;
    logic       busy;
    logic       done;

    always #5 clk = ~clk;

    lcd_ctrl #(
        .PWRUP_CYC   (P),
        .E_PULSE_CYC (EP),
        .CMD_WAIT_CYC(CW),
        .CLR_WAIT_CYC(CLR),
        .REFRESH_CYC (REF)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .refresh (refresh),
        .init_sel(init_sel),
        .mux_sel (mux_sel),
        .data_sel(data_sel),
        .DB_sel  (DB_sel),
        .LCD_E   (LCD_E),
        .LCD_RS  (LCD_RS),
        .LCD_RW  (LCD_RW),
        .busy    (busy),
        .done    (done)
    );

    int checks = 0;
    int errors = 0;
    int init_cmd[4]  = '{8'h38, 8'h0C, 8'h06, 8'h01};
    int digit_cnt[4] = '{1, 2, 3, 4};

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Byte the datapath would put on DB for the current select outputs.
    function automatic int pin_db();
        if (!DB_sel) return 8'hCC;
        if (!data_sel) return init_cmd[init_sel];
        return 8'h30 + digit_cnt[mux_sel];
    endfunction

    // Timeline model: seg -1 power-up, 0..3 init cmds, 4 address, 5..8 digits
    // (MS first), 9 idle; age = cycles spent in the segment.
    int seg = -1;
    int age = 0;
    int pend = 0;
    int acnt = 0;
    bit started = 0;
    bit rst_seen = 0;

    function automatic int cmd_len(input int s);
        return 1 + EP + ((s == 3) ? CLR : CW);
    endfunction

    function automatic int exp_db(input int s);
        if (s < 4) return init_cmd[s];
        if (s == 4) return 8'hCC;
        return 8'h30 + digit_cnt[8 - s];
    endfunction

    always @(posedge clk) begin
        int rq;
        started  = 1;
        rst_seen = rst;
        if (rst) begin
            seg = -1; age = 0; pend = 0; acnt = 0;
        end else begin
            rq = refresh;
`ifdef LCD_AUTO_REFRESH_EN
            if (acnt == REF - 1) begin rq = 1; acnt = 0; end
            else acnt = acnt + 1;
`endif
            if (rq != 0 && seg != 9) pend = 1;
            if (seg == -1) begin
                if (age == P - 1) begin seg = 0; age = 0; end
                else age = age + 1;
            end else if (seg == 9) begin
                if (rq != 0 || pend != 0) begin seg = 4; age = 0; pend = 0; end
                else age = age + 1;
            end else begin
                if (age == cmd_len(seg) - 1) begin seg = seg + 1; age = 0; end
                else age = age + 1;
            end
        end
    end

    int cyc = 0;
    int done_cnt = 0;
    bit e_prev = 0;
    int rise_cyc[$];
    int rise_db[$];

    always @(negedge clk) begin
        if (started) begin
            if (seg == -1) begin
                chk("pwr_E", LCD_E, 0);
                chk("pwr_busy", busy, 1);
                chk("pwr_done", done, 0);
                chk("pwr_RS", LCD_RS, 0);
                chk("pwr_sels", {init_sel, mux_sel, data_sel, DB_sel}, 6'b000001);
            end else if (seg == 9) begin
                chk("idle_E", LCD_E, 0);
                chk("idle_busy", busy, 0);
                chk("idle_done", done, (age == 0) ? 1 : 0);
            end else begin
                chk("cmd_E", LCD_E, (age >= 1 && age <= EP) ? 1 : 0);
                chk("cmd_RS", LCD_RS, (seg >= 5) ? 1 : 0);
                chk("cmd_DB", pin_db(), exp_db(seg));
                chk("cmd_busy", busy, 1);
                chk("cmd_done", done, 0);
            end
            chk("RW", LCD_RW, 0);
            if (rst_seen) cyc = 0;
            else cyc = cyc + 1;
            if (LCD_E && !e_prev) begin
                rise_cyc.push_back(cyc);
                rise_db.push_back(pin_db());
            end
            e_prev = LCD_E;
            if (done) done_cnt = done_cnt + 1;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!done && n < budget);
        if (!done) chk(name, done, 1);
    endtask

    task automatic pulse_refresh();
        refresh = 1'b1;
        tick();
        refresh = 1'b0;
    endtask

    initial begin
        int d0;
        int r0;
        int n;
        rst = 1'b1;
        refresh = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        // Power-up, init and the automatic first frame.
        wait_done("timeout_first_frame", 400);
        chk("first_done_cycle", cyc, 97);
        chk("rises_init_frame", rise_cyc.size(), 9);
        if (rise_cyc.size() >= 9) begin
            chk("first_rise_cycle", rise_cyc[0], 11);
            chk("init_cmd_period", rise_cyc[1] - rise_cyc[0], 8);
            chk("clear_period", rise_cyc[4] - rise_cyc[3], 23);
            chk("db_init0", rise_db[0], 8'h38);
            chk("db_init3", rise_db[3], 8'h01);
            chk("db_addr", rise_db[4], 8'hCC);
            chk("db_digit3", rise_db[5], 8'h34);
            chk("db_digit0", rise_db[8], 8'h31);
        end
        tick();
        chk("busy_after_frame", busy, 0);

        // Refresh from idle.
        repeat (4) tick();
        d0 = done_cnt;
        r0 = rise_cyc.size();
        pulse_refresh();
        chk("refresh_busy", busy, 1);
        chk("refresh_setup_E", LCD_E, 0);
        chk("refresh_setup_db", pin_db(), 8'hCC);
        wait_done("timeout_refresh_frame", 100);
        tick();
        chk("refresh_done_cnt", done_cnt - d0, 1);
        chk("refresh_rises", rise_cyc.size() - r0, 5);

        // Three requests during a frame coalesce into one extra frame.
        repeat (3) tick();
        d0 = done_cnt;
        r0 = rise_cyc.size();
        pulse_refresh();
        repeat (3) begin
            repeat (10) tick();
            pulse_refresh();
        end
        wait_done("timeout_coalesce_1", 100);
        wait_done("timeout_coalesce_2", 100);
        repeat (100) tick();
        chk("coalesce_done_cnt", done_cnt - d0, 2);
        chk("coalesce_rises", rise_cyc.size() - r0, 10);
        chk("coalesce_idle", busy, 0);

        // Reset while E is high during a digit command.
        pulse_refresh();
        n = 0;
        while (!(LCD_E && LCD_RS) && n < 100) begin tick(); n++; end
        chk("digit_E_seen", LCD_E & LCD_RS, 1);
        rst = 1'b1;
        tick();
        chk("abort_E", LCD_E, 0);
        chk("abort_busy", busy, 1);
        chk("abort_DB_sel", DB_sel, 1);
        chk("abort_RS", LCD_RS, 0);
        rise_cyc.delete();
        rise_db.delete();
        rst = 1'b0;
        wait_done("timeout_rerun", 400);
        chk("rerun_done_cycle", cyc, 97);
        chk("rerun_rises", rise_cyc.size(), 9);

        // Long idle with refresh tied low.
        d0 = done_cnt;
        r0 = rise_cyc.size();
        repeat (1000) tick();
`ifdef LCD_AUTO_REFRESH_EN
        chk("auto_frames_min", (done_cnt - d0 >= 4) ? 1 : 0, 1);
`else
        chk("idle_no_frames", done_cnt - d0, 0);
        chk("idle_no_rises", rise_cyc.size() - r0, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
